// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// drives datapath strobes combinationally, counts retired instructions and traps faults.
module multicycle_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [31:0] instruction,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic [2:0]  state,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic        wb_sel,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [31:0] retired
);

    localparam logic [5:0] OPCODE_RTYPE = 6'h00;
    localparam logic [5:0] OPCODE_J     = 6'h02;
    localparam logic [5:0] OPCODE_BEQ   = 6'h04;
    localparam logic [5:0] OPCODE_ADDI  = 6'h08;
    localparam logic [5:0] OPCODE_ANDI  = 6'h0C;
    localparam logic [5:0] OPCODE_ORI   = 6'h0D;
    localparam logic [5:0] OPCODE_LW    = 6'h23;
    localparam logic [5:0] OPCODE_SW    = 6'h2B;

    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_FAULT  = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE        = 2'd0,
        FC_MEM_TIMEOUT = 2'd1,
        FC_BAD_OPCODE  = 2'd2
    } fault_code_t;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2
    } pc_src_t;

    typedef struct packed {
        logic supported;
        logic jump;
        logic branch;
        logic load;
        logic store;
        logic alu;
    } op_class_t;

    function automatic op_class_t classify(input logic [5:0] opcode);
        op_class_t c;
        c = '0;
        case (opcode)
            OPCODE_RTYPE, OPCODE_ADDI, OPCODE_ANDI, OPCODE_ORI: c.alu = 1'b1;
            OPCODE_LW:  c.load   = 1'b1;
            OPCODE_SW:  c.store  = 1'b1;
            OPCODE_BEQ: c.branch = 1'b1;
            OPCODE_J:   c.jump   = 1'b1;
            default: ;
        endcase
        c.supported = c.alu | c.load | c.store | c.branch | c.jump;
        return c;
    endfunction

    state_t      state_q;
    fault_code_t fault_code_q;
    logic        fault_q;
    logic [31:0] retired_q;
    logic [7:0]  wait_cnt;

    op_class_t op;
    state_t    boundary_state;
    pc_src_t   pc_sel;
    logic      mem_phase;
    logic      timed_out;
    logic      retire;

    // Only the opcode field steers sequencing; operand fields belong to the datapath.
    logic unused_instr_fields;
    assign unused_instr_fields = ^instruction[25:0];

    assign op             = classify(instruction[31:26]);
    assign boundary_state = run ? ST_FETCH : ST_IDLE;
    assign mem_phase      = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign timed_out      = mem_phase && !mem_ready && (wait_cnt == WAIT_LIMIT);
    assign retire         = ((state_q == ST_EXEC) && (op.jump || op.branch))
                         || ((state_q == ST_MEM) && mem_ready && op.store)
                         || (state_q == ST_WB);

    // NOTE: registered state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
            retired_q    <= '0;
            wait_cnt     <= '0;
        end else begin
            if (retire) begin
                retired_q <= retired_q + 32'd1;
            end

            // Any cycle that is not a stalled memory cycle leaves the counter at zero,
            // so it is already clear on entry to FETCH or MEM.
            if (mem_phase && !mem_ready) begin
                wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= '0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (run) state_q <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (mem_ready) begin
                        state_q <= ST_DECODE;
                    end else if (timed_out) begin
                        state_q      <= ST_FAULT;
                        fault_q      <= 1'b1;
                        fault_code_q <= FC_MEM_TIMEOUT;
                    end
                end
                ST_DECODE: begin
                    if (op.supported) begin
                        state_q <= ST_EXEC;
                    end else begin
                        state_q      <= ST_FAULT;
                        fault_q      <= 1'b1;
                        fault_code_q <= FC_BAD_OPCODE;
                    end
                end
                ST_EXEC: begin
                    if (op.jump || op.branch) begin
                        state_q <= boundary_state;
                    end else if (op.load || op.store) begin
                        state_q <= ST_MEM;
                    end else if (op.alu) begin
                        state_q <= ST_WB;
                    end else begin
                        // Instruction register changed under us after DECODE.
                        state_q      <= ST_FAULT;
                        fault_q      <= 1'b1;
                        fault_code_q <= FC_BAD_OPCODE;
                    end
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        state_q <= op.store ? boundary_state : ST_WB;
                    end else if (timed_out) begin
                        state_q      <= ST_FAULT;
                        fault_q      <= 1'b1;
                        fault_code_q <= FC_MEM_TIMEOUT;
                    end
                end
                ST_WB: begin
                    state_q <= boundary_state;
                end
                ST_FAULT: ;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // NOTE: every strobe gets its default before the case, so no path through
    // this block leaves an output unassigned and no latch is inferred.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_sel       = PC_SEQ;
        reg_write    = 1'b0;
        wb_sel       = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            ST_EXEC: begin
                if (op.jump) begin
                    pc_write = 1'b1;
                    pc_sel   = PC_JUMP;
                end else if (op.branch) begin
                    pc_write = alu_zero;
                    pc_sel   = PC_BRANCH;
                end
            end
            ST_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = op.store;
            end
            ST_WB: begin
                reg_write = 1'b1;
                wb_sel    = op.load;
            end
            default: ;
        endcase
    end

    assign state      = state_q;
    assign pc_src     = pc_sel;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: per-instruction cycle expectations are
// built from the phase rules of each opcode class and compared every cycle.
module tb_multicycle_sequencer;

    localparam int unsigned TIMEOUT = 4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [31:0] instruction;
    logic        alu_zero;
    logic        mem_ready;
    logic [2:0]  state;
    logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write;
    logic [1:0]  pc_src;
    logic        reg_write, wb_sel, fault;
    logic [1:0]  fault_code;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_retired;
    bit          model_idle;

    typedef struct packed {
        logic [2:0] st;
        logic [8:0] strb;
        logic       rdy;
    } cyc_t;

    cyc_t exp_q[$];
    logic [8:0] strb_obs;

    always #5 clk = ~clk;

    multicycle_sequencer #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .run(run), .instruction(instruction),
        .alu_zero(alu_zero), .mem_ready(mem_ready), .state(state),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .wb_sel(wb_sel), .fault(fault),
        .fault_code(fault_code), .retired(retired)
    );

    assign strb_obs = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, reg_write, wb_sel};

    function automatic logic [8:0] pack_strb(input logic req, input logic we, input logic asel,
                                             input logic irw, input logic pcw, input logic [1:0] src,
                                             input logic rw, input logic wbs);
        return {req, we, asel, irw, pcw, src, rw, wbs};
    endfunction

    task automatic add_cycle(input logic [2:0] st, input logic [8:0] s, input logic rdy);
        exp_q.push_back('{st: st, strb: s, rdy: rdy});
    endtask

    // Expected cycles for one instruction starting in FETCH. A wait count equal to
    // TIMEOUT models a memory that never answers; the list then stops at the fault.
    task automatic build_instr(input logic [5:0] op, input int fw, input int mw, input logic zero);
        bit is_alu, is_ok;
        exp_q.delete();
        is_alu = (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
        is_ok  = is_alu || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_J);
        for (int i = 0; i < fw; i++) add_cycle(3'd1, pack_strb(1, 0, 0, 0, 0, 2'd0, 0, 0), 1'b0);
        if (fw >= int'(TIMEOUT)) return;
        add_cycle(3'd1, pack_strb(1, 0, 0, 1, 1, 2'd0, 0, 0), 1'b1);
        add_cycle(3'd2, '0, 1'($urandom));
        if (!is_ok) return;
        if (op == OP_J)        add_cycle(3'd3, pack_strb(0, 0, 0, 0, 1, 2'd2, 0, 0), 1'($urandom));
        else if (op == OP_BEQ) add_cycle(3'd3, pack_strb(0, 0, 0, 0, zero, 2'd1, 0, 0), 1'($urandom));
        else                   add_cycle(3'd3, '0, 1'($urandom));
        if (op == OP_LW || op == OP_SW) begin
            for (int i = 0; i < mw; i++) add_cycle(3'd4, pack_strb(1, op == OP_SW, 1, 0, 0, 2'd0, 0, 0), 1'b0);
            if (mw >= int'(TIMEOUT)) return;
            add_cycle(3'd4, pack_strb(1, op == OP_SW, 1, 0, 0, 2'd0, 0, 0), 1'b1);
        end
        if (is_alu || op == OP_LW) add_cycle(3'd5, pack_strb(0, 0, 0, 0, 0, 2'd0, 1, op == OP_LW), 1'($urandom));
    endtask

    // Drives the expected-cycle list (up to limit entries, all if negative) and compares
    // state, strobes, retired and fault outputs in every cycle. run_body: 0/1 level, 2 random.
    task automatic play(input string name, input logic [5:0] op, input logic zero, input int run_body,
                        input logic run_end, input bit retires, input int limit);
        logic [31:0] word;
        int n;
        word = {op, 26'($urandom)};
        if (model_idle) begin
            @(negedge clk);
            run = 1'b1; instruction = word; mem_ready = 1'($urandom); alu_zero = 1'($urandom);
            #1;
            checks++;
            if (state !== 3'd0 || strb_obs !== 9'd0 || retired !== model_retired) begin
                errors++;
                $display("FAIL %s idle: state=%0d strobes=%b retired=%0d, expected state=0 strobes=0 retired=%0d",
                         name, state, strb_obs, retired, model_retired);
            end
            model_idle = 1'b0;
        end
        n = (limit < 0) ? exp_q.size() : limit;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            instruction = word;
            alu_zero    = (exp_q[i].st == 3'd3) ? zero : 1'($urandom);
            mem_ready   = exp_q[i].rdy;
            if (retires && i == exp_q.size() - 1) run = run_end;
            else run = (run_body == 2) ? 1'($urandom) : 1'(run_body);
            #1;
            checks++;
            if (state !== exp_q[i].st || strb_obs !== exp_q[i].strb || retired !== model_retired
                || fault !== 1'b0 || fault_code !== 2'd0) begin
                errors++;
                $display("FAIL %s cycle %0d: state=%0d strobes=%b retired=%0d fault=%b code=%0d, expected state=%0d strobes=%b retired=%0d fault=0 code=0",
                         name, i, state, strb_obs, retired, fault, fault_code, exp_q[i].st, exp_q[i].strb, model_retired);
            end
        end
        if (retires && n == exp_q.size()) begin
            model_retired++;
            model_idle = !run_end;
        end
    endtask

    task automatic apply_reset(input string name);
        @(negedge clk);
        reset = 1'b1; run = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0; run = 1'b0; mem_ready = 1'($urandom);
        #1;
        checks++;
        if (state !== 3'd0 || strb_obs !== 9'd0 || retired !== 32'd0 || fault !== 1'b0 || fault_code !== 2'd0) begin
            errors++;
            $display("FAIL %s reset: state=%0d strobes=%b retired=%0d fault=%b code=%0d, expected all zero",
                     name, state, strb_obs, retired, fault, fault_code);
        end
        model_retired = '0;
        model_idle    = 1'b1;
    endtask

    task automatic expect_fault_hold(input string name, input logic [1:0] code);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            run = 1'b1; mem_ready = 1'($urandom); alu_zero = 1'($urandom);
            #1;
            checks++;
            if (state !== 3'd7 || strb_obs !== 9'd0 || fault !== 1'b1 || fault_code !== code) begin
                errors++;
                $display("FAIL %s hold %0d: state=%0d strobes=%b fault=%b code=%0d, expected state=7 strobes=0 fault=1 code=%0d",
                         name, i, state, strb_obs, fault, fault_code, code);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b1; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0; run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (state !== 3'd0 || strb_obs !== 9'd0 || retired !== 32'd0 || fault !== 1'b0 || fault_code !== 2'd0) begin
                errors++;
                $display("FAIL reset_idle %0d: state=%0d strobes=%b retired=%0d fault=%b code=%0d, expected all zero",
                         i, state, strb_obs, retired, fault, fault_code);
            end
            @(negedge clk);
            mem_ready = 1'($urandom);
        end
        model_retired = '0;
        model_idle    = 1'b1;
    endtask

    task automatic test_addi();
        build_instr(OP_ADDI, 0, 0, 1'b0);
        play("addi", OP_ADDI, 1'b0, 1, 1'b1, 1'b1, -1);
    endtask

    task automatic test_lw_wait();
        build_instr(OP_LW, 0, 3, 1'b0);
        play("lw_wait", OP_LW, 1'b0, 1, 1'b1, 1'b1, -1);
    endtask

    task automatic test_beq();
        build_instr(OP_BEQ, 0, 0, 1'b0);
        play("beq_nt", OP_BEQ, 1'b0, 1, 1'b1, 1'b1, -1);
        build_instr(OP_BEQ, 1, 0, 1'b1);
        play("beq_t", OP_BEQ, 1'b1, 1, 1'b1, 1'b1, -1);
    endtask

    task automatic test_back_to_back();
        logic [5:0] seq [5];
        seq = '{OP_J, OP_SW, OP_ORI, OP_ANDI, OP_RTYPE};
        foreach (seq[k]) begin
            build_instr(seq[k], 0, 0, 1'b0);
            play("back_to_back", seq[k], 1'b0, 1, 1'b1, 1'b1, -1);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [8];
        logic [5:0] op;
        logic       zero;
        ops = '{OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW};
        for (int k = 0; k < 40; k++) begin
            op   = ops[$urandom_range(0, 7)];
            zero = 1'($urandom);
            build_instr(op, $urandom_range(0, TIMEOUT - 1), $urandom_range(0, TIMEOUT - 1), zero);
            play("random", op, zero, 2, ($urandom_range(0, 3) != 0), 1'b1, -1);
        end
    endtask

    task automatic test_halt_sw();
        build_instr(OP_SW, 0, 2, 1'b0);
        play("halt_sw", OP_SW, 1'b0, 0, 1'b0, 1'b1, -1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            run = 1'b0; mem_ready = 1'($urandom);
            #1;
            checks++;
            if (state !== 3'd0 || strb_obs !== 9'd0 || retired !== model_retired) begin
                errors++;
                $display("FAIL halt_sw idle %0d: state=%0d strobes=%b retired=%0d, expected state=0 strobes=0 retired=%0d",
                         i, state, strb_obs, retired, model_retired);
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        build_instr(OP_SW, 0, 3, 1'b0);
        play("reset_mid_mem", OP_SW, 1'b0, 1, 1'b1, 1'b1, 5);
        @(negedge clk);
        reset = 1'b1; run = 1'b1; mem_ready = 1'b0;
        #1;
        checks++;
        if (state !== 3'd4 || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_mem pre: state=%0d mem_req=%b, expected state=4 mem_req=1", state, mem_req);
        end
        @(negedge clk);
        reset = 1'b0; run = 1'b0;
        #1;
        checks++;
        if (state !== 3'd0 || strb_obs !== 9'd0 || retired !== 32'd0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_mem post: state=%0d strobes=%b retired=%0d fault=%b, expected all zero",
                     state, strb_obs, retired, fault);
        end
        model_retired = '0;
        model_idle    = 1'b1;
    endtask

    task automatic test_timeout_fetch();
        apply_reset("timeout_fetch");
        build_instr(OP_ADDI, TIMEOUT, 0, 1'b0);
        play("timeout_fetch", OP_ADDI, 1'b0, 1, 1'b1, 1'b0, -1);
        expect_fault_hold("timeout_fetch", 2'd1);
    endtask

    task automatic test_timeout_mem();
        apply_reset("timeout_mem");
        build_instr(OP_LW, 0, TIMEOUT, 1'b0);
        play("timeout_mem", OP_LW, 1'b0, 1, 1'b1, 1'b0, -1);
        expect_fault_hold("timeout_mem", 2'd1);
    endtask

    task automatic test_bad_opcode();
        apply_reset("bad_opcode");
        build_instr(6'h3F, 0, 0, 1'b0);
        play("bad_opcode", 6'h3F, 1'b0, 1, 1'b1, 1'b0, -1);
        expect_fault_hold("bad_opcode", 2'd2);
        apply_reset("bad_opcode_clear");
    endtask

    initial begin
        reset       = 1'b1;
        run         = 1'b0;
        instruction = '0;
        alu_zero    = 1'b0;
        mem_ready   = 1'b0;
        model_retired = '0;
        model_idle    = 1'b1;

        test_reset();
        test_addi();
        test_lw_wait();
        test_beq();
        test_back_to_back();
        test_random();
        test_halt_sw();
        test_reset_mid_mem();
        test_timeout_fetch();
        test_timeout_mem();
        test_bad_opcode();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
